// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 microsequencer: opcodes, control-word bit positions, ALU selects, FSM states.
package sap1_pkg;

    localparam int NUM_T    = 6;
    localparam int OPCODE_W = 4;
    localparam int CW_W     = 12;

    localparam logic [OPCODE_W-1:0] OP_LDA = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_OR  = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_AND = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

    localparam int CW_CP = 11;
    localparam int CW_EP = 10;
    localparam int CW_LM = 9;
    localparam int CW_CE = 8;
    localparam int CW_LI = 7;
    localparam int CW_EI = 6;
    localparam int CW_LA = 5;
    localparam int CW_EA = 4;
    localparam int CW_SU = 3;
    localparam int CW_EU = 2;
    localparam int CW_LB = 1;
    localparam int CW_LO = 0;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_HALT = 2'd2;

    function automatic logic is_alu_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_OR) || (op == OP_AND);
    endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot T-state rotator: clear wins over load (forces T1), load wins over rotate-enable.
module sap1_ring_counter #(
    parameter int NUM_T = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic             en,
    output logic [NUM_T-1:0] ring
);

    logic [NUM_T-1:0] ring_q;
    logic [NUM_T-1:0] ring_d;

    always_comb begin
        ring_d = ring_q;
        if (clear) begin
            ring_d = '0;
        end else if (load) begin
            ring_d = {{(NUM_T-1){1'b0}}, 1'b1};
        end else if (en) begin
            ring_d = {ring_q[NUM_T-2:0], ring_q[NUM_T-1]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ring_q <= '0;
        end else begin
            ring_q <= ring_d;
        end
    end

    assign ring = ring_q;

endmodule

// File: rtl/sap1_microsequencer.sv
// SAP-1 T-state microsequencer: run/halt FSM, opcode decode to control word, ALU select, illegal-opcode flag.
// Optional single-step mode when SAP1_SINGLE_STEP_EN is defined.
module sap1_microsequencer
    import sap1_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
`ifdef SAP1_SINGLE_STEP_EN
    input  logic                step_mode,
    input  logic                step_req,
`endif
    output logic [NUM_T-1:0]    t_state,
    output logic [CW_W-1:0]     ctrl_word,
    output logic [1:0]          alu_op,
    output logic                instr_done,
    output logic                halted,
    output logic                illegal_op
);

    state_t           state_q, state_d;
    logic [1:0]       alu_op_q, alu_op_d;
    logic             illegal_q, illegal_d;
    logic [NUM_T-1:0] ring;
    logic [CW_W-1:0]  cw_raw;
    logic             hold;
    logic             in_run;
    logic             t4_commit;
    logic             hlt_now;
    logic             op_defined;

`ifdef SAP1_SINGLE_STEP_EN
    assign hold = step_mode & ~step_req;
`else
    assign hold = 1'b0;
`endif

    assign in_run     = (state_q == ST_RUN);
    // Opcode side effects happen only on the edge that actually leaves T4.
    assign t4_commit  = in_run & ring[3] & ~hold;
    assign hlt_now    = t4_commit & (opcode == OP_HLT);
    assign op_defined = (opcode == OP_LDA) || is_alu_op(opcode) ||
                        (opcode == OP_OUT) || (opcode == OP_HLT);

    sap1_ring_counter #(.NUM_T(NUM_T)) u_ring (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (hlt_now),
        .load    ((state_q == ST_IDLE) & run),
        .en      (in_run & ~hold),
        .ring    (ring)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (run)     state_d = ST_RUN;
            ST_RUN:  if (hlt_now) state_d = ST_HALT;
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        alu_op_d  = alu_op_q;
        illegal_d = illegal_q | (t4_commit & ~op_defined);
        if (t4_commit) begin
            case (opcode)
                OP_ADD:  alu_op_d = ALU_ADD;
                OP_SUB:  alu_op_d = ALU_SUB;
                OP_OR:   alu_op_d = ALU_OR;
                OP_AND:  alu_op_d = ALU_AND;
                default: alu_op_d = alu_op_q;
            endcase
        end
    end

    always_comb begin
        cw_raw = '0;
        if (ring[0]) begin
            cw_raw[CW_EP] = 1'b1;
            cw_raw[CW_LM] = 1'b1;
        end else if (ring[1]) begin
            cw_raw[CW_CP] = 1'b1;
        end else if (ring[2]) begin
            cw_raw[CW_CE] = 1'b1;
            cw_raw[CW_LI] = 1'b1;
        end else if (ring[3]) begin
            if (opcode == OP_LDA || is_alu_op(opcode)) begin
                cw_raw[CW_EI] = 1'b1;
                cw_raw[CW_LM] = 1'b1;
            end else if (opcode == OP_OUT) begin
                cw_raw[CW_EA] = 1'b1;
                cw_raw[CW_LO] = 1'b1;
            end
        end else if (ring[4]) begin
            if (opcode == OP_LDA) begin
                cw_raw[CW_CE] = 1'b1;
                cw_raw[CW_LA] = 1'b1;
            end else if (is_alu_op(opcode)) begin
                cw_raw[CW_CE] = 1'b1;
                cw_raw[CW_LB] = 1'b1;
            end
        end else if (ring[5]) begin
            if (is_alu_op(opcode)) begin
                cw_raw[CW_EU] = 1'b1;
                cw_raw[CW_LA] = 1'b1;
                cw_raw[CW_SU] = (opcode == OP_SUB);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            alu_op_q  <= ALU_ADD;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_op_q  <= alu_op_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobes are suppressed while a single-step hold is in effect so no load repeats.
    assign t_state    = in_run ? ring : '0;
    assign ctrl_word  = (in_run & ~hold) ? cw_raw : '0;
    assign alu_op     = alu_op_q;
    assign instr_done = in_run & ring[5];
    assign halted     = (state_q == ST_HALT);
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_sap1_microsequencer.sv
// Bench for sap1_microsequencer: directed scenarios plus randomized runs against an instruction-level reference model.
module tb_sap1_microsequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic [3:0]  opcode;
    logic [5:0]  t_state;
    logic [11:0] ctrl_word;
    logic [1:0]  alu_op;
    logic        instr_done;
    logic        halted;
    logic        illegal_op;
`ifdef SAP1_SINGLE_STEP_EN
    logic        step_mode;
    logic        step_req;
`endif

    int n_chk = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 run, 2 halt; m_t is the T-state number 1..6.
    int         m_mode;
    int         m_t;
    logic [1:0] m_alu;
    logic       m_ill;

    always #5 clk = ~clk;

    sap1_microsequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .opcode     (opcode),
`ifdef SAP1_SINGLE_STEP_EN
        .step_mode  (step_mode),
        .step_req   (step_req),
`endif
        .t_state    (t_state),
        .ctrl_word  (ctrl_word),
        .alu_op     (alu_op),
        .instr_done (instr_done),
        .halted     (halted),
        .illegal_op (illegal_op)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic m_hold();
`ifdef SAP1_SINGLE_STEP_EN
        return step_mode && !step_req;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [11:0] exp_cw(input int t, input logic [3:0] op);
        logic alu;
        alu = (op >= 4'd1) && (op <= 4'd4);
        case (t)
            1: return 12'h600;
            2: return 12'h800;
            3: return 12'h180;
            4: return (op == 4'h0 || alu) ? 12'h240 : (op == 4'hE) ? 12'h011 : 12'h000;
            5: return (op == 4'h0) ? 12'h120 : alu ? 12'h102 : 12'h000;
            6: return !alu ? 12'h000 : (op == 4'h2) ? 12'h02C : 12'h024;
            default: return 12'h000;
        endcase
    endfunction

    task automatic model_update();
        if (!reset_n) begin
            m_mode = 0; m_t = 0; m_alu = 2'b00; m_ill = 1'b0;
        end else if (m_mode == 0) begin
            if (run) begin m_mode = 1; m_t = 1; end
        end else if (m_mode == 1 && !m_hold()) begin
            if (m_t == 4 && opcode == 4'hF) begin
                m_mode = 2; m_t = 0;
            end else begin
                if (m_t == 4) begin
                    if (opcode >= 4'd1 && opcode <= 4'd4) m_alu = 2'(opcode - 4'd1);
                    if (opcode >= 4'd5 && opcode <= 4'd13) m_ill = 1'b1;
                end
                m_t = (m_t == 6) ? 1 : m_t + 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [5:0]  e_t;
        logic [11:0] e_cw;
        e_t  = (m_mode == 1) ? (6'd1 << (m_t - 1)) : 6'd0;
        e_cw = (m_mode == 1 && !m_hold()) ? exp_cw(m_t, opcode) : 12'h000;
        chk({tag, ".t_state"},    32'(t_state),    32'(e_t));
        chk({tag, ".ctrl_word"},  32'(ctrl_word),  32'(e_cw));
        chk({tag, ".alu_op"},     32'(alu_op),     32'(m_alu));
        chk({tag, ".instr_done"}, 32'(instr_done), 32'(m_mode == 1 && m_t == 6));
        chk({tag, ".halted"},     32'(halted),     32'(m_mode == 2));
        chk({tag, ".illegal_op"}, 32'(illegal_op), 32'(m_ill));
        chk({tag, ".wbus_drv"},
            32'($countones({ctrl_word[10], ctrl_word[8], ctrl_word[6], ctrl_word[4], ctrl_word[2]}) <= 1),
            32'd1);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        #1;
        model_update();
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        model_update();
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        model_update();
        check_all({tag, ".held"});
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        run     = 1'b0;
        opcode  = 4'h0;
`ifdef SAP1_SINGLE_STEP_EN
        step_mode = 1'b0;
        step_req  = 1'b0;
`endif
        #3;
        model_update();
        check_all("por");
        do_reset("rst0");

        // Reset in T5 of ADD, then restart from T1.
        run = 1'b1; opcode = 4'h1;
        cycle("add_t1");
        chk("t1_cw_const", 32'(ctrl_word), 32'h600);
        chk("t1_ts_const", 32'(t_state), 32'h01);
        run = 1'b0;
        repeat (4) cycle("add_pre");
        chk("t5_before_rst", 32'(t_state), 32'h10);
        do_reset("rst_t5");
        chk("rst_cw_const", 32'(ctrl_word), 32'h000);
        run = 1'b1;
        cycle("restart_t1");
        chk("restart_cw", 32'(ctrl_word), 32'h600);
        run = 1'b0;

        // ADD
        repeat (5) cycle("add");
        chk("add_t6_cw", 32'(ctrl_word), 32'h024);
        chk("add_t6_done", 32'(instr_done), 32'd1);

        // SUB, then ADD restores alu_op
        cycle("sub_t1"); opcode = 4'h2;
        repeat (5) cycle("sub");
        chk("sub_t6_cw", 32'(ctrl_word), 32'h02C);
        chk("sub_alu", 32'(alu_op), 32'd1);
        cycle("add2_t1"); opcode = 4'h1;
        repeat (4) cycle("add2");
        chk("add2_alu", 32'(alu_op), 32'd0);

        // Illegal opcode acts as NOP and flags
        repeat (2) cycle("pre_ill");
        opcode = 4'hA;
        repeat (3) cycle("ill");
        chk("ill_t4_cw", 32'(ctrl_word), 32'h000);
        chk("ill_t4_flag", 32'(illegal_op), 32'd0);
        cycle("ill_t5");
        chk("ill_t5_flag", 32'(illegal_op), 32'd1);
        repeat (2) cycle("ill_tail");
        chk("post_ill_fetch", 32'(ctrl_word), 32'h600);

        // HLT, then run is ignored
        opcode = 4'hF;
        repeat (3) cycle("hlt");
        chk("hlt_t4_cw", 32'(ctrl_word), 32'h000);
        cycle("hlt_enter");
        chk("hlt_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            run = ~run;
            cycle("halt_hold");
        end
        chk("halt_ts", 32'(t_state), 32'h00);

`ifdef SAP1_SINGLE_STEP_EN
        do_reset("rst_step");
        step_mode = 1'b1; step_req = 1'b0; run = 1'b1; opcode = 4'h0;
        cycle("step_t1");
        run = 1'b0;
        for (int p = 0; p < 3; p++) begin
            repeat (2) cycle("step_wait");
            step_req = 1'b1;
            cycle("step_pulse");
            step_req = 1'b0;
        end
        cycle("step_end");
        chk("step_t4", 32'(t_state), 32'h08);
        step_mode = 1'b0;
`endif

        // Randomized runs
        for (int ep = 0; ep < 40; ep++) begin
            do_reset("rnd_rst");
            for (int c = 0; c < 60; c++) begin
                run    = ($urandom_range(0, 3) != 0);
                opcode = ($urandom_range(0, 24) == 0) ? 4'hF : 4'($urandom_range(0, 14));
`ifdef SAP1_SINGLE_STEP_EN
                step_mode = ($urandom_range(0, 3) == 0);
                step_req  = $urandom_range(0, 1) != 0;
`endif
                if ($urandom_range(0, 99) == 0) begin
                    do_reset("rnd_midrst");
                end else begin
                    cycle("rnd");
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
